dccm_arb: RTL and testbench
===========================

# dccm_arb

Parametrised multi-channel front end for the data closely-coupled memory (DCCM). It generalises the single-LSU DCCM hookup to NUM_PORTS requesters, such as the LSU plus a debug or DMA master. Each cycle it grants at most one valid/ready request, checks the address range, and drives a fixed two-stage pipeline to a 1-cycle-latency SRAM. It returns exactly one tagged response per accepted request on the requesting channel.

## Interface
Parameters:
- NUM_PORTS, 2: requester channel count, 1..8.
- XLEN, 32: address and data width.
- DEPTH, 1024: memory depth in XLEN-bit words, power of two.
- TAG_WIDTH, 4: request tag width, echoed on the response.

Ports (per-channel buses are flattened, channel i occupies slice i):
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_PORTS  request present.
- req_ready  out  NUM_PORTS  request accepted this cycle.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*XLEN  byte address.
- req_wdata  in  NUM_PORTS*XLEN  write data.
- req_be  in  NUM_PORTS*XLEN/8  write byte enables, ignored for reads.
- req_tag  in  NUM_PORTS*TAG_WIDTH  request tag.
- rsp_valid  out  NUM_PORTS  response for channel i, 1-cycle pulse.
- rsp_rdata  out  XLEN  read data, shared by all channels.
- rsp_tag  out  TAG_WIDTH  echoed tag, shared.
- rsp_err  out  1  response error, shared.
- mem_ren  out  1  SRAM read strobe.
- mem_wen  out  1  SRAM write strobe.
- mem_addr  out  log2(DEPTH)  SRAM word index.
- mem_wdata  out  XLEN  SRAM write data.
- mem_wbe  out  XLEN/8  SRAM byte enables.
- mem_rdata  in  XLEN  SRAM read data, valid 1 cycle after mem_ren.

## Operation
- Arbitration:
  - Round-robin among asserted req_valid bits.
  - Priority search starts at rr_ptr+1 mod NUM_PORTS.
  - rr_ptr updates to the granted index only on a grant.
  - rr_ptr resets to NUM_PORTS-1, so port 0 wins first.
- Handshake:
  - req_ready[i] = grant[i]; at most one bit is high.
  - req_ready is combinational from req_valid.
  - A request completes when req_valid[i] & req_ready[i].
  - Requesters must hold all request fields stable while valid and not ready.
- Stage A (registered on accept): we, port, word index, wdata, be, tag, err.
  - Word index = addr[log2(DEPTH)+1:2]; addr[1:0] is ignored.
  - In stage A, drive mem_addr from the stored word index.
  - Assert mem_wen (write) or mem_ren (read) only when err=0.
- Stage B (registered from A): port, tag, err, we.
  - rsp_valid[port] = 1.
  - rsp_rdata = mem_rdata for an error-free read, else 0.
  - rsp_tag = stored tag.
  - rsp_err = stored err.
- Writes also receive a response (ack) with rsp_rdata = 0.
- There is no response backpressure; requesters must accept every response.
- Read-after-write to the same word in back-to-back accepts needs no forwarding: the write commits at the end of the A cycle, before the following read reaches the SRAM.
- When no request is in flight: mem_ren = mem_wen = 0, and mem_addr, mem_wdata, mem_wbe hold their last values.

## Timing
- Throughput: one accepted request per cycle, sustained.
- Latency: accepted at cycle T; SRAM access at T+1; rsp_valid at T+2.
  - rsp_rdata is combinational from mem_rdata in T+2.
- Response order equals accept order, across all channels.
- Reset values:
  - req_ready, rsp_valid, rsp_err, mem_ren, mem_wen = 0.
  - rsp_rdata, rsp_tag, mem_addr, mem_wdata, mem_wbe = 0.
  - Stage valid bits = 0; rr_ptr = NUM_PORTS-1.
- Reset while a request is in flight: stages A and B are cleared, so no response is issued and no SRAM strobe occurs in the cycle after reset. Requesters must reissue.
- While rst is high, req_ready = 0.
- All req_valid low: no grant, and rr_ptr holds.

## Configuration
- Macro DCCM_ARB_RANGE_CHECK_EN.
- Defined:
  - An address >= DEPTH*4 sets err=1.
  - No SRAM strobe is issued for that request.
  - Its response has rsp_err=1 and rsp_rdata=0, with the same latency as a normal response.
- Undefined:
  - No range check; the address wraps modulo DEPTH*4 by index truncation.
  - rsp_err is tied to 0.

## Test plan
- Single read, port 0, addr 0x10, SRAM word 4 = 0xDEADBEEF -> mem_ren with mem_addr=4 at T+1; rsp_valid[0] with rdata 0xDEADBEEF and the request tag at T+2.
- Write port 1, addr 0x20, wdata 0x12345678, be 0b0011, then read 0x20 from port 0 in the next cycle:
  - The write produces mem_wen with mem_wbe=0b0011 and a write ack on port 1.
  - The read returns 0x????5678, where the low half is new and the upper half is the prior content.
- All ports hold req_valid for 6 cycles with NUM_PORTS=2 -> grants alternate 0,1,0,1,0,1; responses arrive in the same order at 2-cycle offset.
- Out-of-range read of addr 0x1000 with DEPTH=1024:
  - Macro defined: no mem_ren; rsp_err=1, rdata=0.
  - Macro undefined: mem_addr=0; rsp_err=0.
- rst asserted for one cycle, one cycle after an accept -> no rsp_valid and no SRAM strobe follow; the next grant goes to port 0.
- Port 1 valid alone for 3 cycles with tags 1,2,3 -> back-to-back grants, rsp tags 1,2,3 on consecutive cycles.

Source files
------------

// File: rtl/dccm_arb_if.sv
// Bundles the dccm_arb requester channels and the SRAM port into one interface.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface dccm_arb_if #(
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 1024,
  parameter int TAG_WIDTH = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = XLEN / 8;

  logic [NUM_PORTS-1:0]           req_valid;
  logic [NUM_PORTS-1:0]           req_ready;
  logic [NUM_PORTS-1:0]           req_we;
  logic [NUM_PORTS*XLEN-1:0]      req_addr;
  logic [NUM_PORTS*XLEN-1:0]      req_wdata;
  logic [NUM_PORTS*BW-1:0]        req_be;
  logic [NUM_PORTS*TAG_WIDTH-1:0] req_tag;
  logic [NUM_PORTS-1:0]           rsp_valid;
  logic [XLEN-1:0]                rsp_rdata;
  logic [TAG_WIDTH-1:0]           rsp_tag;
  logic                           rsp_err;
  logic                           mem_ren;
  logic                           mem_wen;
  logic [AW-1:0]                  mem_addr;
  logic [XLEN-1:0]                mem_wdata;
  logic [BW-1:0]                  mem_wbe;
  logic [XLEN-1:0]                mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, req_tag, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wbe
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, req_tag, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wbe
  );
endinterface

// File: rtl/dccm_arb.sv
// Round-robin NUM_PORTS-channel front end driving a 1-cycle-latency DCCM SRAM.
// Define DCCM_ARB_RANGE_CHECK_EN to flag addresses >= DEPTH*4 as errors instead of wrapping.
module dccm_arb #(
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 1024,
  parameter int TAG_WIDTH = 4
) (
  input logic       clk,
  input logic       rst,
  dccm_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = XLEN / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW-1:0] RR_RST = PW'(NUM_PORTS - 1);

  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        gnt_idx, cand;
  logic                 gnt_any, gnt_ok, hit, req_err;

  logic                 a_valid_q, a_valid_d, a_we_q, a_we_d, a_err_q, a_err_d;
  logic [PW-1:0]        a_port_q, a_port_d;
  logic [AW-1:0]        a_idx_q, a_idx_d;
  logic [XLEN-1:0]      a_wdata_q, a_wdata_d;
  logic [BW-1:0]        a_be_q, a_be_d;
  logic [TAG_WIDTH-1:0] a_tag_q, a_tag_d;

  logic                 b_valid_q, b_valid_d, b_we_q, b_we_d, b_err_q, b_err_d;
  logic [PW-1:0]        b_port_q, b_port_d;
  logic [TAG_WIDTH-1:0] b_tag_q, b_tag_d;

  // Round-robin search: first valid channel after the last granted one.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    hit     = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand    = PW'((int'(rr_q) + i) % NUM_PORTS);
      hit     = bus.req_valid[cand] & ~gnt_any;
      gnt_idx = hit ? cand : gnt_idx;
      gnt_any = gnt_any | hit;
    end
  end

  assign gnt_ok = gnt_any & ~rst;
  assign rr_d   = gnt_ok ? gnt_idx : rr_q;

  always_comb begin
    bus.req_ready = '0;
    if (gnt_ok) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end else begin
      bus.req_ready = '0;
    end
  end

`ifdef DCCM_ARB_RANGE_CHECK_EN
  assign req_err = |bus.req_addr[int'(gnt_idx)*XLEN + AW + 2 +: XLEN - AW - 2];
`else
  assign req_err = 1'b0;
`endif

  // Stage A captures the granted request; its fields double as the held SRAM drive.
  always_comb begin
    a_valid_d = gnt_ok;
    a_we_d    = a_we_q;
    a_err_d   = a_err_q;
    a_port_d  = a_port_q;
    a_idx_d   = a_idx_q;
    a_wdata_d = a_wdata_q;
    a_be_d    = a_be_q;
    a_tag_d   = a_tag_q;
    if (gnt_ok) begin
      a_we_d    = bus.req_we[gnt_idx];
      a_err_d   = req_err;
      a_port_d  = gnt_idx;
      a_idx_d   = bus.req_addr[int'(gnt_idx)*XLEN + 2 +: AW];
      a_wdata_d = bus.req_wdata[int'(gnt_idx)*XLEN +: XLEN];
      a_be_d    = bus.req_be[int'(gnt_idx)*BW +: BW];
      a_tag_d   = bus.req_tag[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
    end else begin
      a_we_d    = a_we_q;
    end
  end

  always_comb begin
    b_valid_d = a_valid_q;
    b_we_d    = b_we_q;
    b_err_d   = b_err_q;
    b_port_d  = b_port_q;
    b_tag_d   = b_tag_q;
    if (a_valid_q) begin
      b_we_d   = a_we_q;
      b_err_d  = a_err_q;
      b_port_d = a_port_q;
      b_tag_d  = a_tag_q;
    end else begin
      b_we_d   = b_we_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= RR_RST;
      a_valid_q <= 1'b0;
      a_we_q    <= 1'b0;
      a_err_q   <= 1'b0;
      a_port_q  <= '0;
      a_idx_q   <= '0;
      a_wdata_q <= '0;
      a_be_q    <= '0;
      a_tag_q   <= '0;
      b_valid_q <= 1'b0;
      b_we_q    <= 1'b0;
      b_err_q   <= 1'b0;
      b_port_q  <= '0;
      b_tag_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      a_valid_q <= a_valid_d;
      a_we_q    <= a_we_d;
      a_err_q   <= a_err_d;
      a_port_q  <= a_port_d;
      a_idx_q   <= a_idx_d;
      a_wdata_q <= a_wdata_d;
      a_be_q    <= a_be_d;
      a_tag_q   <= a_tag_d;
      b_valid_q <= b_valid_d;
      b_we_q    <= b_we_d;
      b_err_q   <= b_err_d;
      b_port_q  <= b_port_d;
      b_tag_q   <= b_tag_d;
    end
  end

  // Strobes and responses are suppressed while rst is high so a flushed request leaves no trace.
  always_comb begin
    bus.mem_ren   = a_valid_q & ~a_we_q & ~a_err_q & ~rst;
    bus.mem_wen   = a_valid_q & a_we_q & ~a_err_q & ~rst;
    bus.mem_addr  = a_idx_q;
    bus.mem_wdata = a_wdata_q;
    bus.mem_wbe   = a_be_q;
    bus.rsp_valid = '0;
    bus.rsp_tag   = b_tag_q;
    bus.rsp_err   = b_valid_q & b_err_q & ~rst;
    bus.rsp_rdata = '0;
    if (b_valid_q && !rst) begin
      bus.rsp_valid[b_port_q] = 1'b1;
    end else begin
      bus.rsp_valid = '0;
    end
    if (b_valid_q && !b_we_q && !b_err_q && !rst) begin
      bus.rsp_rdata = bus.mem_rdata;
    end else begin
      bus.rsp_rdata = '0;
    end
  end
endmodule

// File: tb/tb_dccm_arb.sv
// Randomised scoreboard bench for dccm_arb: a word-array reference model predicts grants,
// SRAM accesses and responses; a separate monitor checks them cycle by cycle.
module tb_dccm_arb;
  localparam int NP    = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int TW    = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = XLEN / 8;

  typedef struct {
    int             cyc;
    int             port;
    logic [TW-1:0]  tag;
    logic           err;
    logic [XLEN-1:0] rdata;
    bit             cancel;
  } rsp_t;

  typedef struct {
    int              cyc;
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata;
    logic [BW-1:0]   be;
    bit              cancel;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dccm_arb_if #(.NUM_PORTS(NP), .XLEN(XLEN), .DEPTH(DEPTH), .TAG_WIDTH(TW)) bus ();
  dccm_arb #(.NUM_PORTS(NP), .XLEN(XLEN), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rr     = NP - 1;
  int rsp_rd = 0;
  int acc_rd = 0;
  rsp_t rsp_q[$];
  acc_t acc_q[$];
  logic [XLEN-1:0] ref_mem[DEPTH];
  logic [XLEN-1:0] sram[DEPTH];
  logic [XLEN-1:0] mem_rd_q = '0;
  logic            sram_init = 1'b0;

  logic            v[NP];
  logic            we[NP];
  logic [XLEN-1:0] addr[NP];
  logic [XLEN-1:0] wdata[NP];
  logic [BW-1:0]   be[NP];
  logic [TW-1:0]   tag[NP];

  function automatic logic [XLEN-1:0] seed(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : ((XLEN'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_w, input logic [XLEN-1:0] new_w,
                                            input logic [BW-1:0] be_w);
    logic [XLEN-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be_w[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural SRAM: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= seed(i);
      sram_init <= 1'b1;
    end else if (bus.mem_wen) begin
      sram[bus.mem_addr] <= merge(sram[bus.mem_addr], bus.mem_wdata, bus.mem_wbe);
    end
    if (bus.mem_ren) mem_rd_q <= sram[bus.mem_addr];
  end
  assign bus.mem_rdata = mem_rd_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model for one accepted request.
  task automatic accept(input int g);
    rsp_t r;
    acc_t a;
    logic [AW-1:0] idx;
    logic err;
    idx = addr[g][AW+1:2];
`ifdef DCCM_ARB_RANGE_CHECK_EN
    err = (addr[g] >= XLEN'(DEPTH * 4));
`else
    err = 1'b0;
`endif
    r.cyc = cyc + 2; r.port = g; r.tag = tag[g]; r.err = err; r.rdata = '0; r.cancel = 1'b0;
    if (!err) begin
      a.cyc = cyc + 1; a.we = we[g]; a.addr = idx; a.wdata = wdata[g]; a.be = be[g]; a.cancel = 1'b0;
      acc_q.push_back(a);
      if (we[g]) ref_mem[idx] = merge(ref_mem[idx], wdata[g], be[g]);
      else r.rdata = ref_mem[idx];
    end
    rsp_q.push_back(r);
  endtask

  // One cycle: present the current requests, check the grant, model the accept.
  task automatic step(input bit do_rst);
    int g;
    logic [NP-1:0] exp_rdy;
    @(posedge clk);
    #1;
    rst = do_rst;
    if (do_rst) begin
      foreach (rsp_q[i]) rsp_q[i].cancel = 1'b1;
      foreach (acc_q[i]) acc_q[i].cancel = 1'b1;
      rr = NP - 1;
    end
    for (int i = 0; i < NP; i++) begin
      bus.req_valid[i] = v[i];
      bus.req_we[i]    = we[i];
      bus.req_addr[i*XLEN +: XLEN]  = addr[i];
      bus.req_wdata[i*XLEN +: XLEN] = wdata[i];
      bus.req_be[i*BW +: BW]        = be[i];
      bus.req_tag[i*TW +: TW]       = tag[i];
    end
    #1;
    g = -1;
    if (!do_rst) begin
      for (int k = 1; k <= NP; k++) if (g < 0 && v[(rr + k) % NP]) g = (rr + k) % NP;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      rr = g;
      accept(g);
      v[g] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                         input logic [BW-1:0] b, input logic [TW-1:0] t);
    v[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b; tag[i] = t;
  endtask

  task automatic new_req(input int i);
    int sel;
    logic [XLEN-1:0] a;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) a = 32'h0000_1000 + XLEN'($urandom_range(0, 4095));
    else if (sel == 1) a = XLEN'($urandom);
    else a = XLEN'($urandom_range(0, 15)) * 32'd4 + XLEN'($urandom_range(0, 3));
    set_req(i, 1'($urandom_range(0, 1)), a, XLEN'($urandom), BW'($urandom), TW'($urandom));
  endtask

  // Monitor: compares SRAM strobes and responses against the queued expectations.
  initial begin
    logic [NP-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        while (rsp_rd < rsp_q.size() && rsp_q[rsp_rd].cancel) rsp_rd++;
        if (rsp_rd < rsp_q.size() && rsp_q[rsp_rd].cyc == cyc) begin
          exp_v = '0;
          exp_v[rsp_q[rsp_rd].port] = 1'b1;
          check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
          check("rsp_tag", 64'(bus.rsp_tag), 64'(rsp_q[rsp_rd].tag));
          check("rsp_err", 64'(bus.rsp_err), 64'(rsp_q[rsp_rd].err));
          check("rsp_rdata", 64'(bus.rsp_rdata), 64'(rsp_q[rsp_rd].rdata));
          rsp_rd++;
        end else begin
          check("rsp_idle", 64'(bus.rsp_valid), 64'd0);
        end
        while (acc_rd < acc_q.size() && acc_q[acc_rd].cancel) acc_rd++;
        if (acc_rd < acc_q.size() && acc_q[acc_rd].cyc == cyc) begin
          check("mem_strobe", 64'({bus.mem_wen, bus.mem_ren}),
                64'({acc_q[acc_rd].we, ~acc_q[acc_rd].we}));
          check("mem_addr", 64'(bus.mem_addr), 64'(acc_q[acc_rd].addr));
          if (acc_q[acc_rd].we) begin
            check("mem_wdata", 64'(bus.mem_wdata), 64'(acc_q[acc_rd].wdata));
            check("mem_wbe", 64'(bus.mem_wbe), 64'(acc_q[acc_rd].be));
          end
          acc_rd++;
        end else begin
          check("mem_idle", 64'({bus.mem_wen, bus.mem_ren}), 64'd0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NP; i++) set_req(i, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
    // Reset with both channels requesting: no grant may appear.
    repeat (3) step(1'b1);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_mem_wbe", 64'(bus.mem_wbe), 64'd0);
    check("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    for (int i = 0; i < NP; i++) v[i] = 1'b0;

    set_req(0, 1'b0, 32'h10, '0, '0, 4'd5);
    step(1'b0);
    set_req(1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 4'd6);
    step(1'b0);
    set_req(0, 1'b0, 32'h20, '0, '0, 4'd7);
    step(1'b0);
    set_req(0, 1'b0, 32'h1000, '0, '0, 4'd8);
    step(1'b0);
    for (int k = 1; k <= 3; k++) begin
      set_req(1, 1'b0, XLEN'(k * 4), '0, '0, TW'(k));
      step(1'b0);
    end
    repeat (3) step(1'b0);

    // Reset one cycle after an accept flushes it; port 0 wins next.
    set_req(0, 1'b0, 32'h8, '0, '0, 4'd9);
    step(1'b0);
    set_req(0, 1'b0, 32'h4, '0, '0, 4'd1);
    set_req(1, 1'b0, 32'hC, '0, '0, 4'd2);
    step(1'b1);
    step(1'b0);
    check("post_rst_grant", 64'(bus.req_ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NP; i++) if (!v[i]) set_req(i, 1'b0, XLEN'(c * 8 + i * 4), '0, '0, TW'(c));
      step(1'b0);
    end

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) if (!v[i] && $urandom_range(0, 9) < 6) new_req(i);
      step(1'b0);
    end
    for (int i = 0; i < NP; i++) v[i] = 1'b0;
    repeat (4) step(1'b0);
    check("rsp_drained", 64'(rsp_rd), 64'(rsp_q.size()));
    check("acc_drained", 64'(acc_rd), 64'(acc_q.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
